pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage that consumes `sel_pc` from the condition-control stage and redirects fetch to a branch target when a conditional branch is taken. It holds the PC, issues one request at a time to instruction memory over a req/ack handshake, and presents one fetched instruction with its PC to decode. Taken-branch redirects squash the instruction held in the stage and any fetch already in flight.

---
 rtl/pc_fetch_unit.sv | 99 +++++++++
 tb/tb_pc_fetch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage.
// Holds the PC and issues one instruction-memory request at a time over a
// req/ack handshake. It presents one fetched instruction, with its address,
// to decode. A taken branch (sel_pc) squashes the presented instruction. A
// fetch that is already in flight completes, and its data is then discarded.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_pc,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus
);

  typedef enum logic {
    FETCH = 1'b0,  // request outstanding at pc
    VALID = 1'b1   // instruction held for decode, no request
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  redir_pc;  // branch target that waits for an in-flight fetch to finish
  logic               drop;      // data of the in-flight fetch belongs to the squashed path

  // NOTE: imem_req is gated by rst so that no request is seen while reset is
  // held, even though the state register already reads FETCH.
  assign imem_req  = (state == FETCH) & ~rst;
  assign imem_addr = pc;
  assign pc_plus   = pc_out + STEP;

  // Fetch sequencing: handshake, redirect handling and the decode-side register.
  // NOTE: every register here uses non-blocking assignment. Each branch below
  // then reads the pre-edge values of pc/drop/redir_pc, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redir_pc    <= '0;
      drop        <= 1'b0;
      instr       <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (sel_pc) begin
              // Redirect coincides with the returning data: discard it and go
              // straight to the target.
              pc   <= branch_target;
              drop <= 1'b0;
            end else if (drop) begin
              // Late data from the squashed path: discard it and restart at the saved target.
              pc   <= redir_pc;
              drop <= 1'b0;
            end else begin
              instr       <= imem_rdata;
              pc_out      <= pc;
              pc          <= pc + STEP;
              instr_valid <= 1'b1;
              state       <= VALID;
            end
          end else if (sel_pc) begin
            // The request stays outstanding. Keep imem_addr stable and remember
            // where to go once the ack arrives.
            drop     <= 1'b1;
            redir_pc <= branch_target;
          end
        end
        VALID: begin
          if (sel_pc) begin
            // Squash wins over stall.
            instr_valid <= 1'b0;
            pc          <= branch_target;
            state       <= FETCH;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit.
// A behavioural model of the fetch stage predicts outputs every cycle. Directed
// scenarios add hand-computed literal checks, including the final sequence of
// presented instruction addresses. A second instance checks address wrap.
module tb_pc_fetch_unit;

  localparam int          AW   = 32;
  localparam int          IW   = 32;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] WRPC = 32'hFFFF_FFFC;
  localparam logic [31:0] MARK = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sel_pc = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          stall = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] pc_plus;

  // Second instance, used only for the wrap-around case.
  logic          w_rst = 1'b1;
  logic          w_sel = 1'b0;
  logic [AW-1:0] w_target = '0;
  logic          w_stall = 1'b0;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic          w_ack = 1'b0;
  logic [IW-1:0] w_rdata = '0;
  logic [IW-1:0] w_instr;
  logic          w_valid;
  logic [AW-1:0] w_pc_out;
  logic [AW-1:0] w_pc_plus;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .sel_pc(sel_pc), .branch_target(branch_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc_out(pc_out), .pc_plus(pc_plus)
  );

  pc_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(WRPC), .PC_STEP(4)) dut_w (
    .clk(clk), .rst(w_rst), .sel_pc(w_sel), .branch_target(w_target),
    .stall(w_stall), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .instr(w_instr),
    .instr_valid(w_valid), .pc_out(w_pc_out), .pc_plus(w_pc_plus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder: acks a request after wait_cfg idle request cycles.
  // Returned data is the address XOR MARK. force_ack injects stray acks.
  // ---------------------------------------------------------------------------
  int   wait_cfg  = 0;
  int   wait_cnt  = 0;
  logic force_ack = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (force_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        wait_cnt   = 0;
      end else if (imem_req) begin
        if (wait_cnt >= wait_cfg) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ MARK;
          wait_cnt   = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hBAD0_BAD0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Behavioural model, expressed in terms of the stage's observable behaviour:
  // it is either fetching (next_addr) or holding one instruction for decode.
  // A redirect during an unfinished fetch makes that fetch's data unwanted.
  // ---------------------------------------------------------------------------
  logic [31:0] next_addr   = RPC;
  logic        holding     = 1'b0;
  logic        unwanted    = 1'b0;
  logic [31:0] pending_tgt = '0;
  logic [31:0] held_instr  = '0;
  logic [31:0] held_addr   = '0;
  logic        exp_req;

  logic [31:0] presented[$];
  logic        prev_valid = 1'b0;
  logic        saw_114    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      next_addr  = RPC;
      holding    = 1'b0;
      unwanted   = 1'b0;
      held_instr = '0;
      held_addr  = '0;
    end else if (!holding) begin
      if (imem_ack) begin
        if (sel_pc) begin
          next_addr = branch_target;
          unwanted  = 1'b0;
        end else if (unwanted) begin
          next_addr = pending_tgt;
          unwanted  = 1'b0;
        end else begin
          held_instr = imem_rdata;
          held_addr  = next_addr;
          next_addr  = next_addr + 32'd4;
          holding    = 1'b1;
        end
      end else if (sel_pc) begin
        unwanted    = 1'b1;
        pending_tgt = branch_target;
      end
    end else if (sel_pc) begin
      next_addr = branch_target;
      holding   = 1'b0;
    end else if (!stall) begin
      holding = 1'b0;
    end
    #1;
    exp_req = !rst && !holding;
    check("req", imem_req, exp_req);
    if (exp_req) check("addr", imem_addr, next_addr);
    check("valid", instr_valid, holding);
    if (holding) begin
      check("instr", instr, held_instr);
      check("pc_out", pc_out, held_addr);
      check("pc_plus", pc_plus, held_addr + 32'd4);
    end
    if (instr_valid && !prev_valid) presented.push_back(pc_out);
    prev_valid = instr_valid;
    if (imem_req && imem_addr == 32'h0000_0114) saw_114 = 1'b1;
  end

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 50);
    check(name, instr_valid, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_seq[9] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                              32'h200, 32'h300, 32'h400, 32'h100};

  initial begin
    int          n;
    logic [31:0] first_addr;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_addr", imem_addr, RPC);

    // Zero-wait, no stall: 0x100, 0x104, 0x108
    rst = 1'b0;
    #1;
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'h100);
    n = 0;
    while (presented.size() < 3 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("zero_wait_count", presented.size(), 3);
    check("zw_valid", instr_valid, 1'b1);
    check("zw_pc_out", pc_out, 32'h108);
    check("zw_pc_plus", pc_plus, 32'h10C);

    // Ack delayed 3 cycles: request held steady for 4 cycles
    wait_cfg   = 3;
    n          = 0;
    first_addr = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) break;
      if (imem_req) begin
        if (n == 0) first_addr = imem_addr;
        else check("delay_addr_stable", imem_addr, first_addr);
        n++;
      end
    end
    check("delay_req_cycles", n, 4);
    check("delay_addr", first_addr, 32'h10C);
    check("delay_pc_out", pc_out, 32'h10C);

    // Stall for 5 cycles in VALID
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", instr_valid, 1'b1);
      check("stall_pc_out", pc_out, 32'h10C);
      check("stall_instr", instr, 32'h10C ^ MARK);
      check("stall_no_req", imem_req, 1'b0);
    end
    stall    = 1'b0;
    wait_cfg = 0;
    wait_valid("wait_110");
    check("pc_out_110", pc_out, 32'h110);

    // Squash in VALID with stall held: target 0x200
    stall         = 1'b1;
    sel_pc        = 1'b1;
    branch_target = 32'h200;
    @(negedge clk);
    sel_pc = 1'b0;
    stall  = 1'b0;
    check("squash_valid", instr_valid, 1'b0);
    check("squash_req", imem_req, 1'b1);
    check("squash_addr", imem_addr, 32'h200);
    wait_valid("wait_200");
    check("pc_out_200", pc_out, 32'h200);

    // Redirect while 0x204 is outstanding, ack arrives 2 cycles later
    wait_cfg = 2;
    @(negedge clk);
    check("out_addr", imem_addr, 32'h204);
    sel_pc        = 1'b1;
    branch_target = 32'h300;
    @(negedge clk);
    sel_pc = 1'b0;
    check("out_addr_hold", imem_addr, 32'h204);
    @(negedge clk);
    @(negedge clk);
    check("drop_next_req", imem_req, 1'b1);
    check("drop_next_addr", imem_addr, 32'h300);
    check("drop_not_valid", instr_valid, 1'b0);
    wait_valid("wait_300");
    check("pc_out_300", pc_out, 32'h300);

    // Redirect coincident with ack for 0x304
    wait_cfg = 0;
    @(negedge clk);
    check("coin_addr", imem_addr, 32'h304);
    sel_pc        = 1'b1;
    branch_target = 32'h400;
    @(negedge clk);
    sel_pc = 1'b0;
    check("coin_req", imem_req, 1'b1);
    check("coin_next_addr", imem_addr, 32'h400);
    check("coin_not_valid", instr_valid, 1'b0);
    wait_valid("wait_400");
    check("pc_out_400", pc_out, 32'h400);

    // Reset during an outstanding fetch, with stray acks while held
    wait_cfg = 3;
    @(negedge clk);
    check("mid_req", imem_req, 1'b1);
    @(negedge clk);
    rst       = 1'b1;
    force_ack = 1'b1;
    #1;
    check("mid_rst_req", imem_req, 1'b0);
    check("mid_rst_valid", instr_valid, 1'b0);
    check("mid_rst_addr", imem_addr, RPC);
    check("mid_rst_pc_out", pc_out, 32'h0);
    repeat (2) @(negedge clk);
    check("late_ack_valid", instr_valid, 1'b0);
    check("late_ack_addr", imem_addr, RPC);
    force_ack = 1'b0;
    wait_cfg  = 0;
    rst       = 1'b0;
    wait_valid("wait_after_rst");
    check("pc_out_after_rst", pc_out, 32'h100);

    // Sequence of presented addresses: squashed/dropped ones never appear
    check("presented_count", presented.size(), 9);
    for (int i = 0; i < 9; i++)
      if (i < presented.size()) check($sformatf("presented[%0d]", i), presented[i], exp_seq[i]);
    check("never_req_114", saw_114, 1'b0);

    // Wrap-around instance: RESET_PC = 0xFFFFFFFC
    @(negedge clk);
    w_ack   = 1'b1;
    w_rdata = 32'h1234_5678;
    w_rst   = 1'b0;
    #1;
    check("wrap_req0", w_req, 1'b1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_valid", w_valid, 1'b1);
    check("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
    check("wrap_pc_plus", w_pc_plus, 32'h0000_0000);
    check("wrap_instr", w_instr, 32'h1234_5678);
    @(negedge clk);
    check("wrap_req1", w_req, 1'b1);
    check("wrap_addr1", w_addr, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
